// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_MIN_CYCLES_PER_BIT = 3;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input.
module sync_ff #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= {STAGES{RESET_VALUE}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receive front end: synchronises rx, samples mid-bit, and emits
// good bytes, framing-error strobes and a line-break level separately.
//
// state | meaning
// IDLE  | waiting for rx low
// START | timing to mid start bit, rejecting glitches
// DATA  | shifting in 8 data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | framing error seen, waiting for rx to return high
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CLOCK_SCALE_BITS-1:0] cycles_per_bit_i,
    input  logic                        rx_i,
    output logic [7:0]                  data_out_o,
    output logic                        data_available_o,
    output logic                        framing_error_o,
    output logic                        line_break_o,
    output logic                        busy_o
);

    localparam int CW = CLOCK_SCALE_BITS + 1;

    logic          rx_s;
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] pm1_q;
    logic [CW-1:0] hm1_q;
    logic [CW-1:0] pm1_d;
    logic [CW-1:0] hm1_d;
    logic [CW-1:0] period_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_out_q;
    logic          data_available_q;
    logic          framing_error_q;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_rx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Bit timing is clamped to a minimum period and latched at frame start.
    always_comb begin
        pm1_d = {1'b0, cycles_per_bit_i};
        if (cycles_per_bit_i < CLOCK_SCALE_BITS'(UART_MIN_CYCLES_PER_BIT)) begin
            pm1_d = CW'(UART_MIN_CYCLES_PER_BIT);
        end
        period_d = pm1_d + CW'(1);
        hm1_d    = (period_d >> 1) - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            pm1_q            <= '0;
            hm1_q            <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            data_out_q       <= '0;
            data_available_q <= 1'b0;
            framing_error_q  <= 1'b0;
        end else begin
            data_available_q <= 1'b0;
            framing_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        pm1_q   <= pm1_d;
                        hm1_q   <= hm1_d;
                    end
                end
                START: begin
                    if (cnt_q == hm1_q) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == pm1_q) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == pm1_q) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_out_q       <= shift_q;
                            data_available_q <= 1'b1;
                            state_q          <= IDLE;
                        end else begin
                            framing_error_q <= 1'b1;
                            state_q         <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out_o       = data_out_q;
    assign data_available_o = data_available_q;
    assign framing_error_o  = framing_error_q;
    assign line_break_o     = (state_q == BREAK);
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: table of frames plus corner-case sequences.
module tb_uart_rx_sampler;

    logic        clk;
    logic        rst;
    logic [15:0] cpb;
    logic        rx;
    logic [7:0]  data_out;
    logic        dav;
    logic        fe;
    logic        lb;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_rx_sampler #(
        .CLOCK_SCALE_BITS (16),
        .SYNC_STAGES      (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cycles_per_bit_i (cpb),
        .rx_i             (rx),
        .data_out_o       (data_out),
        .data_available_o (dav),
        .framing_error_o  (fe),
        .line_break_o     (lb),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    logic [7:0] rxq[$];
    int   dav_cnt = 0;
    int   fe_cnt = 0;
    int   both_err = 0;
    int   width_err = 0;
    int   last_dav_cyc = 0;
    logic busy_at_dav = 1'b1;
    logic prev_dav = 1'b0;
    logic prev_fe = 1'b0;

    always @(negedge clk) begin
        if (dav) begin
            rxq.push_back(data_out);
            dav_cnt++;
            last_dav_cyc = cyc;
            busy_at_dav  = busy;
            if (fe) both_err++;
        end
        if (fe) fe_cnt++;
        if (dav && prev_dav) width_err++;
        if (fe && prev_fe) width_err++;
        prev_dav = dav;
        prev_fe  = fe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int b);
        hold_rx(1'b0, b);
        for (int i = 0; i < 8; i++) hold_rx(d[i], b);
        hold_rx(stop, b);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [15:0] cpb;
        int          bitc;
        logic [7:0]  data;
        logic        stop;
        int          exp_dav;
        int          exp_fe;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[8];

    int d0, f0, lat;
    logic [7:0] v0, v1;

    initial begin
        vecs[0] = '{16'd15, 16, 8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{16'd15, 16, 8'hA3, 1'b0, 0, 1, 8'h55};
        vecs[2] = '{16'd9,  10, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{16'd9,  10, 8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{16'd1,  4,  8'h81, 1'b1, 1, 0, 8'h81};
        vecs[5] = '{16'd3,  4,  8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[6] = '{16'd0,  4,  8'h7E, 1'b1, 1, 0, 8'h7E};
        vecs[7] = '{16'd7,  8,  8'hC6, 1'b0, 0, 1, 8'h7E};

        rx  = 1'b1;
        rst = 1'b1;
        cpb = 16'd15;
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_dav", 32'(dav), 32'h0);
        check("reset_fe", 32'(fe), 32'h0);
        check("reset_lb", 32'(lb), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            cpb = vecs[i].cpb;
            d0  = dav_cnt;
            f0  = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bitc);
            hold_rx(1'b1, 2 * vecs[i].bitc + 10);
            check($sformatf("vec%0d_dav", i), 32'(dav_cnt - d0), 32'(vecs[i].exp_dav));
            check($sformatf("vec%0d_fe", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'h0);
        end

        // Good byte latency and busy alignment
        cpb = 16'd15;
        d0  = dav_cnt;
        lat = cyc;
        send_frame(8'h55, 1'b1, 16);
        hold_rx(1'b1, 40);
        lat = last_dav_cyc - lat;
        check("lat_dav_count", 32'(dav_cnt - d0), 32'd1);
        check("lat_in_window", 32'((lat >= 153) && (lat <= 155)), 32'd1);
        check("lat_busy_at_dav", 32'(busy_at_dav), 32'h0);
        check("lat_data", 32'(data_out), 32'h55);

        // Start glitch shorter than half a bit
        d0 = dav_cnt;
        f0 = fe_cnt;
        hold_rx(1'b0, 4);
        hold_rx(1'b1, 40);
        check("glitch_dav", 32'(dav_cnt - d0), 32'd0);
        check("glitch_fe", 32'(fe_cnt - f0), 32'd0);
        check("glitch_data", 32'(data_out), 32'h55);
        check("glitch_busy", 32'(busy), 32'h0);

        // Framing error followed by a held-low break
        d0 = dav_cnt;
        f0 = fe_cnt;
        send_frame(8'hA3, 1'b0, 16);
        hold_rx(1'b0, 100);
        check("break_lb_high", 32'(lb), 32'h1);
        check("break_fe", 32'(fe_cnt - f0), 32'd1);
        check("break_dav", 32'(dav_cnt - d0), 32'd0);
        check("break_data", 32'(data_out), 32'h55);
        hold_rx(1'b1, 60);
        check("break_lb_low", 32'(lb), 32'h0);
        check("break_busy", 32'(busy), 32'h0);
        check("break_no_frame", 32'(dav_cnt - d0), 32'd0);

        // Back-to-back frames with no idle gap
        cpb = 16'd9;
        rxq.delete();
        send_frame(8'hA3, 1'b1, 10);
        send_frame(8'h0F, 1'b1, 10);
        hold_rx(1'b1, 40);
        check("b2b_count", 32'(rxq.size()), 32'd2);
        v0 = (rxq.size() > 0) ? rxq[0] : 8'hxx;
        v1 = (rxq.size() > 1) ? rxq[1] : 8'hxx;
        check("b2b_first", 32'(v0), 32'hA3);
        check("b2b_second", 32'(v1), 32'h0F);

        // Reset during data bit 4 of 0xFF, then a clean frame
        cpb = 16'd15;
        d0  = dav_cnt;
        f0  = fe_cnt;
        hold_rx(1'b0, 16);
        for (int i = 0; i < 4; i++) hold_rx(1'b1, 16);
        hold_rx(1'b1, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_rx(1'b1, 40);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_dav", 32'(dav_cnt - d0), 32'd0);
        check("rstmid_fe", 32'(fe_cnt - f0), 32'd0);
        check("rstmid_data_cleared", 32'(data_out), 32'h00);
        send_frame(8'h3C, 1'b1, 16);
        hold_rx(1'b1, 40);
        check("rstmid_next_dav", 32'(dav_cnt - d0), 32'd1);
        check("rstmid_next_data", 32'(data_out), 32'h3C);

        check("strobe_overlap", 32'(both_err), 32'd0);
        check("strobe_width", 32'(width_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
